// File: rtl/wb_dual_commit_pkg.sv
// wb_dual_commit_pkg: shared widths, wb_lane record, enable constants and lane helpers for the WB commit stage
package wb_dual_commit_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int REG_W       = 32;
    localparam int REG_AW      = 5;
    localparam int NREG        = 1 << REG_AW;

    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic RST_ENABLE   = 1'b1;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [REG_W-1:0]       reg_t;
    typedef logic [REG_AW-1:0]      reg_addr_t;

    typedef struct packed {
        logic       lv;
        inst_addr_t pc;
        logic       we;
        reg_addr_t  waddr;
        reg_t       wdata;
    } wb_lane_t;

    // A lane really writes only if it holds an instruction, asks to write, and targets a non-r0 register
    function automatic logic lane_gate(wb_lane_t l);
        return l.lv && (l.we == WRITE_ENABLE) && (l.waddr != '0);
    endfunction

    function automatic logic [NREG-1:0] lane_pend(wb_lane_t l);
        return lane_gate(l) ? (NREG'(1) << l.waddr) : '0;
    endfunction

endpackage

// File: rtl/wb_dual_commit_if.sv
// wb_dual_commit_if: MEM pair handshake plus regfile write-port bundle; commit_cnt exists only with WB_COMMIT_CNT_EN
interface wb_dual_commit_if;
    import wb_dual_commit_pkg::*;

    logic             flush;
    logic             wb_stall;
    logic             mem_valid;
    logic             mem_ready;
    logic             mem_lv_1, mem_lv_2;
    inst_addr_t       mem_pc_1, mem_pc_2;
    logic             mem_we_1, mem_we_2;
    reg_addr_t        mem_waddr_1, mem_waddr_2;
    reg_t             mem_wdata_1, mem_wdata_2;
    inst_addr_t       pc_o_1, pc_o_2;
    logic             we_1, we_2;
    reg_addr_t        waddr_1, waddr_2;
    reg_t             wdata_1, wdata_2;
    logic [NREG-1:0]  pend_mask;
`ifdef WB_COMMIT_CNT_EN
    logic [63:0]      commit_cnt;
`endif

    modport master (
`ifdef WB_COMMIT_CNT_EN
        input  commit_cnt,
`endif
        output flush, wb_stall, mem_valid,
        output mem_lv_1, mem_lv_2, mem_pc_1, mem_pc_2, mem_we_1, mem_we_2,
        output mem_waddr_1, mem_waddr_2, mem_wdata_1, mem_wdata_2,
        input  mem_ready, pc_o_1, pc_o_2, we_1, we_2, waddr_1, waddr_2,
        input  wdata_1, wdata_2, pend_mask
    );

    modport slave (
`ifdef WB_COMMIT_CNT_EN
        output commit_cnt,
`endif
        input  flush, wb_stall, mem_valid,
        input  mem_lv_1, mem_lv_2, mem_pc_1, mem_pc_2, mem_we_1, mem_we_2,
        input  mem_waddr_1, mem_waddr_2, mem_wdata_1, mem_wdata_2,
        output mem_ready, pc_o_1, pc_o_2, we_1, we_2, waddr_1, waddr_2,
        output wdata_1, wdata_2, pend_mask
    );

endinterface

// File: rtl/wb_pair_fifo.sv
// wb_pair_fifo: DEPTH x W FIFO with push/pop/flush, exposing count, per-slot valid bits and slot contents
module wb_pair_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  logic [W-1:0]                   din,
    output logic [W-1:0]                   head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [DEPTH-1:0]               vld,
    output logic [DEPTH-1:0][W-1:0]        slots
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rd, wr;

    assign head = slots[rd];

    // Storage and pointers; callers never push when full or pop when empty, so push and pop never hit the same slot
    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            vld   <= '0;
            slots <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (push) begin
                slots[wr] <= din;
                vld[wr]   <= 1'b1;
                wr        <= wr + PW'(1);
            end
            if (pop) begin
                vld[rd] <= 1'b0;
                rd      <= rd + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/wb_dual_commit.sv
// wb_dual_commit: dual-lane WB commit stage; pair FIFO, r0/lane gating, same-register conflict resolution, pend_mask; WB_COMMIT_CNT_EN adds commit_cnt
module wb_dual_commit
    import wb_dual_commit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    wb_dual_commit_if.slave   bus
);
    localparam int EW = $bits(wb_lane_t);
    localparam int CW = $clog2(DEPTH + 1);

    wb_lane_t [1:0]              in_pair, hd;
    logic [2*EW-1:0]             head_raw;
    logic [DEPTH-1:0][2*EW-1:0]  slots;
    logic [DEPTH-1:0]            vld;
    logic [CW-1:0]               count;
    logic [NREG-1:0]             pend;
    logic                        push, commit, g1, g2, clash, lane1_wins;

    // Lane 1 sits in element 0, lane 2 in element 1
    always_comb begin
        in_pair[0] = '{lv: bus.mem_lv_1, pc: bus.mem_pc_1, we: bus.mem_we_1,
                       waddr: bus.mem_waddr_1, wdata: bus.mem_wdata_1};
        in_pair[1] = '{lv: bus.mem_lv_2, pc: bus.mem_pc_2, we: bus.mem_we_2,
                       waddr: bus.mem_waddr_2, wdata: bus.mem_wdata_2};
    end

    assign bus.mem_ready = count != CW'(DEPTH);
    assign push          = bus.mem_valid && bus.mem_ready && !bus.flush;
    assign commit        = (count != '0) && !bus.wb_stall && !bus.flush && (rst != RST_ENABLE);

    wb_pair_fifo #(.W(2 * EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .push  (push),
        .pop   (commit),
        .din   (in_pair),
        .head  (head_raw),
        .count (count),
        .vld   (vld),
        .slots (slots)
    );

    assign hd = head_raw;

    // When both lanes target the same register the younger (larger PC) write survives; ties go to lane 2
    assign g1         = lane_gate(hd[0]);
    assign g2         = lane_gate(hd[1]);
    assign clash      = g1 && g2 && (hd[0].waddr == hd[1].waddr);
    assign lane1_wins = hd[0].pc > hd[1].pc;

    assign bus.we_1    = commit && g1 && !(clash && !lane1_wins);
    assign bus.we_2    = commit && g2 && !(clash && lane1_wins);
    assign bus.pc_o_1  = hd[0].pc;
    assign bus.pc_o_2  = hd[1].pc;
    assign bus.waddr_1 = hd[0].waddr;
    assign bus.waddr_2 = hd[1].waddr;
    assign bus.wdata_1 = hd[0].wdata;
    assign bus.wdata_2 = hd[1].wdata;

    // Pending writes from every buffered entry, for the issue-stage hazard check
    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++)
            pend |= vld[i] ? (lane_pend(slots[i][EW-1:0]) | lane_pend(slots[i][2*EW-1:EW])) : '0;
    end

    assign bus.pend_mask = pend;

`ifdef WB_COMMIT_CNT_EN
    logic [63:0] cnt;

    // Retired-instruction count: every valid lane of a committing pair counts, even if it writes nothing
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE)
            cnt <= '0;
        else if (commit)
            cnt <= cnt + 64'(hd[0].lv) + 64'(hd[1].lv);
    end

    assign bus.commit_cnt = cnt;
`endif

endmodule

// File: tb/tb_wb_dual_commit.sv
// tb_wb_dual_commit: directed scoreboard bench for wb_dual_commit; commit_cnt checks only with WB_COMMIT_CNT_EN
module tb_wb_dual_commit;
    import wb_dual_commit_pkg::*;

    typedef struct packed {
        logic        lv;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } lane_s;

    typedef struct packed {
        logic [1:0] we;
        lane_s      l1;
        lane_s      l2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t mon_e;

    wb_dual_commit_if bus();

    wb_dual_commit #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every presented commit must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.we_1 || bus.we_2) begin
            n_vec++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL commit_unexpected: got we=%b%b waddr=%0d/%0d, required no commit",
                         bus.we_1, bus.we_2, bus.waddr_1, bus.waddr_2);
            end else begin
                mon_e = q.pop_front();
                if ({bus.we_1, bus.we_2} !== mon_e.we ||
                    bus.pc_o_1 !== mon_e.l1.pc || bus.pc_o_2 !== mon_e.l2.pc ||
                    bus.waddr_1 !== mon_e.l1.a || bus.waddr_2 !== mon_e.l2.a ||
                    bus.wdata_1 !== mon_e.l1.d || bus.wdata_2 !== mon_e.l2.d) begin
                    n_bad++;
                    $display("FAIL commit: got we=%b%b pc=%h/%h a=%0d/%0d d=%h/%h, required we=%b%b pc=%h/%h a=%0d/%0d d=%h/%h",
                             bus.we_1, bus.we_2, bus.pc_o_1, bus.pc_o_2, bus.waddr_1, bus.waddr_2,
                             bus.wdata_1, bus.wdata_2, mon_e.we[1], mon_e.we[0], mon_e.l1.pc, mon_e.l2.pc,
                             mon_e.l1.a, mon_e.l2.a, mon_e.l1.d, mon_e.l2.d);
                end
            end
        end
    end

    function automatic lane_s mk(logic lv, logic [31:0] pc, logic we, logic [4:0] a, logic [31:0] d);
        return '{lv, pc, we, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Offer a pair; xw is the hand-computed we pattern it must commit with (00: never presented)
    task automatic offer(input lane_s l1, input lane_s l2, input logic [1:0] xw);
        bus.mem_valid   = 1'b1;
        bus.mem_lv_1    = l1.lv;
        bus.mem_pc_1    = l1.pc;
        bus.mem_we_1    = l1.we;
        bus.mem_waddr_1 = l1.a;
        bus.mem_wdata_1 = l1.d;
        bus.mem_lv_2    = l2.lv;
        bus.mem_pc_2    = l2.pc;
        bus.mem_we_2    = l2.we;
        bus.mem_waddr_2 = l2.a;
        bus.mem_wdata_2 = l2.d;
        if (xw != 2'b00)
            q.push_back('{xw, l1, l2});
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.wb_stall  = 1'b0;
        bus.mem_valid = 1'b0;
        offer(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), 2'b00);
        bus.mem_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", bus.mem_ready, 1);
        chk("rst_we", {bus.we_1, bus.we_2}, 0);
        chk("rst_pend", bus.pend_mask, 0);
        chk("rst_pc_o_1", bus.pc_o_1, 0);
        chk("rst_waddr_2", bus.waddr_2, 0);
        chk("rst_wdata_1", bus.wdata_1, 0);
`ifdef WB_COMMIT_CNT_EN
        chk("rst_cnt", bus.commit_cnt, 0);
`endif

        // 1) plain pair, one-cycle latency and transient pend_mask
        offer(mk(1, 32'h1c000000, 1, 5, 32'hAA), mk(1, 32'h1c000004, 1, 6, 32'hBB), 2'b11);
        tick();
        bus.mem_valid = 1'b0;
        chk("t1_latency_we", {bus.we_1, bus.we_2}, 2'b11);
        chk("t1_pend", bus.pend_mask, 32'h60);
        tick();
        chk("t1_pend_clear", bus.pend_mask, 0);
        chk("t1_we_off", {bus.we_1, bus.we_2}, 0);

        // 2) same-register conflicts: lane1 older/younger, then equal PCs
        offer(mk(1, 32'h1c000010, 1, 7, 32'h11), mk(1, 32'h1c00000c, 1, 7, 32'h22), 2'b10);
        tick();
        chk("t2_pend", bus.pend_mask, 32'h80);
        offer(mk(1, 32'h1c00000c, 1, 7, 32'h33), mk(1, 32'h1c000010, 1, 7, 32'h44), 2'b01);
        tick();
        offer(mk(1, 32'h1c000020, 1, 7, 32'h55), mk(1, 32'h1c000020, 1, 7, 32'h66), 2'b01);
        tick();
        bus.mem_valid = 1'b0;
        tick();

        // 3) r0 write suppressed
        offer(mk(1, 32'h1c000030, 1, 0, 32'h33), mk(1, 32'h1c000034, 1, 3, 32'h44), 2'b01);
        tick();
        bus.mem_valid = 1'b0;
        chk("t3_pend", bus.pend_mask, 32'h8);
        chk("t3_we", {bus.we_1, bus.we_2}, 2'b01);
        tick();

        // 4) stall three cycles while pushing three pairs
        bus.wb_stall = 1'b1;
        offer(mk(1, 32'h1c000040, 1, 1, 32'hA1), mk(1, 32'h1c000044, 1, 2, 32'hA2), 2'b11);
        tick();
        chk("t4_ready_1", bus.mem_ready, 1);
        chk("t4_stall_we_1", {bus.we_1, bus.we_2}, 0);
        offer(mk(1, 32'h1c000048, 1, 8, 32'hB1), mk(1, 32'h1c00004c, 1, 9, 32'hB2), 2'b11);
        tick();
        chk("t4_ready_full", bus.mem_ready, 0);
        chk("t4_stall_we_2", {bus.we_1, bus.we_2}, 0);
        chk("t4_pend", bus.pend_mask, 32'h306);
        offer(mk(1, 32'h1c000050, 1, 10, 32'hC1), mk(1, 32'h1c000054, 1, 11, 32'hC2), 2'b11);
        tick();
        chk("t4_ready_hold", bus.mem_ready, 0);
        chk("t4_stall_we_3", {bus.we_1, bus.we_2}, 0);
        bus.wb_stall = 1'b0;
        #1;
        chk("t4_head_a", bus.waddr_1, 1);
        tick();
        chk("t4_head_b", bus.waddr_1, 8);
        chk("t4_ready_again", bus.mem_ready, 1);
        tick();
        bus.mem_valid = 1'b0;
        chk("t4_head_c", bus.waddr_1, 10);
        tick();
        chk("t4_drained_we", {bus.we_1, bus.we_2}, 0);
        chk("t4_drained_pend", bus.pend_mask, 0);

        // 5) flush with a full FIFO and an offered pair
        bus.wb_stall = 1'b1;
        offer(mk(1, 32'h1c000060, 1, 12, 32'hD1), mk(1, 32'h1c000064, 1, 13, 32'hD2), 2'b00);
        tick();
        offer(mk(1, 32'h1c000068, 1, 14, 32'hE1), mk(1, 32'h1c00006c, 1, 15, 32'hE2), 2'b00);
        tick();
        chk("t5_full", bus.mem_ready, 0);
        bus.flush    = 1'b1;
        bus.wb_stall = 1'b0;
        offer(mk(1, 32'h1c000070, 1, 16, 32'hF1), mk(1, 32'h1c000074, 1, 17, 32'hF2), 2'b00);
        #1;
        chk("t5_flush_we", {bus.we_1, bus.we_2}, 0);
        tick();
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b0;
        chk("t5_post_we", {bus.we_1, bus.we_2}, 0);
        chk("t5_post_pend", bus.pend_mask, 0);
        chk("t5_post_ready", bus.mem_ready, 1);
        tick();
        chk("t5_post_we_2", {bus.we_1, bus.we_2}, 0);

        // 5b) a push accepted-looking in the flush cycle is dropped
        bus.wb_stall = 1'b1;
        offer(mk(1, 32'h1c000080, 1, 18, 32'h61), mk(1, 32'h1c000084, 1, 19, 32'h62), 2'b00);
        tick();
        bus.flush = 1'b1;
        offer(mk(1, 32'h1c000088, 1, 20, 32'h71), mk(1, 32'h1c00008c, 1, 21, 32'h72), 2'b00);
        tick();
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b0;
        bus.wb_stall  = 1'b0;
        chk("t5b_pend", bus.pend_mask, 0);
        chk("t5b_we", {bus.we_1, bus.we_2}, 0);
        tick();
        chk("t5b_push_dropped", {bus.we_1, bus.we_2}, 0);
        offer(mk(1, 32'h1c000100, 1, 22, 32'h81), mk(1, 32'h1c000104, 1, 23, 32'h82), 2'b11);
        tick();
        bus.mem_valid = 1'b0;
        chk("t5b_resume_we", {bus.we_1, bus.we_2}, 2'b11);
        tick();

`ifdef WB_COMMIT_CNT_EN
        // 6) retire counter over lv patterns 11,10,01,11,00
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_cnt_start", bus.commit_cnt, 0);
        offer(mk(1, 32'h1c000200, 1, 1, 32'h1), mk(1, 32'h1c000204, 1, 2, 32'h2), 2'b11);
        tick();
        offer(mk(1, 32'h1c000208, 1, 3, 32'h3), mk(0, 32'h1c00020c, 1, 4, 32'h4), 2'b10);
        tick();
        offer(mk(0, 32'h1c000210, 1, 5, 32'h5), mk(1, 32'h1c000214, 1, 6, 32'h6), 2'b01);
        tick();
        offer(mk(1, 32'h1c000218, 1, 7, 32'h7), mk(1, 32'h1c00021c, 1, 8, 32'h8), 2'b11);
        tick();
        offer(mk(0, 32'h1c000220, 1, 9, 32'h9), mk(0, 32'h1c000224, 1, 10, 32'hA), 2'b00);
        tick();
        bus.mem_valid = 1'b0;
        tick();
        tick();
        chk("t6_cnt", bus.commit_cnt, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_cnt_rst", bus.commit_cnt, 0);
`endif

        // 7) reset while an entry is buffered: nothing commits, entry discarded
        bus.wb_stall = 1'b1;
        offer(mk(1, 32'h1c000300, 1, 24, 32'h91), mk(1, 32'h1c000304, 1, 25, 32'h92), 2'b00);
        tick();
        bus.mem_valid = 1'b0;
        chk("t7_pend_before", bus.pend_mask, 32'h0300_0000);
        rst          = 1'b1;
        bus.wb_stall = 1'b0;
        #1;
        chk("t7_rst_cycle_we", {bus.we_1, bus.we_2}, 0);
        tick();
        rst = 1'b0;
        chk("t7_pend", bus.pend_mask, 0);
        chk("t7_ready", bus.mem_ready, 1);
        chk("t7_we", {bus.we_1, bus.we_2}, 0);
        tick();
        chk("t7_we_after", {bus.we_1, bus.we_2}, 0);

        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
